// File: rtl/v_sel_sequencer_pkg.sv
// Shared constants, state encoding and channel arithmetic for the select sequencer.
// NCH channels are addressed by a SEL_W-bit index; indices NCH..2**SEL_W-1 are never produced.
package v_sel_sequencer_pkg;

    localparam int NCH       = 6;
    localparam int SEL_W     = 3;
    localparam int DWELL_MAX = 16;
    localparam int CNT_W     = $clog2(DWELL_MAX);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Channel index `step` positions after `base`, wrapping NCH-1 -> 0.
    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                  input int unsigned step);
        int unsigned sum;
        sum = int'(base) + step;
        return SEL_W'(sum % NCH);
    endfunction

endpackage

// File: rtl/v_sel_sequencer_rr_pick.sv
// Rotating-priority search: first requesting channel strictly after `last`, wrapping.
// Purely combinational; `any` flags that at least one channel is requesting.
module v_rr_pick
    import v_sel_sequencer_pkg::*;
(
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] pick,
    output logic             any
);

    logic [SEL_W-1:0] off_idx [NCH];
    logic [NCH-1:0]   hit;

    // Candidate gi is the channel gi+1 places after `last`; lower gi has priority.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
        assign off_idx[gi] = wrap_add(last, gi + 1);
        assign hit[gi]     = req[off_idx[gi]];
    end

    always_comb begin
        pick = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                pick = off_idx[i];
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/v_sel_sequencer.sv
// Grants one of six channels at a time for DWELL cycles (or until done), round-robin.
// sel feeds a 3-to-8 decoder, so it only ever carries 0..5 and holds its value between grants.
module v_sel_sequencer
    import v_sel_sequencer_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   req,
    input  logic             done,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             busy
);

    // Out-of-range DWELL falls back to the maximum grant length.
    localparam bit             DWELL_OK   = (DWELL >= 1) && (DWELL <= DWELL_MAX);
    localparam logic [CNT_W-1:0] DWELL_LOAD = DWELL_OK ? CNT_W'(DWELL - 1) : CNT_W'(DWELL_MAX - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [SEL_W-1:0] last_reg;
    logic [SEL_W-1:0] sel_reg;
    logic             valid_reg;
    logic             busy_reg;
    logic             armed_reg;

    logic [SEL_W-1:0] pick;
    logic             any;

    v_rr_pick u_pick (
        .req  (req),
        .last (last_reg),
        .pick (pick),
        .any  (any)
    );

    // armed_reg keeps the first edge after reset release from granting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            last_reg  <= SEL_W'(NCH - 1);
            sel_reg   <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            armed_reg <= 1'b0;
        end else begin
            armed_reg <= 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    if (armed_reg && any) begin
                        sel_reg   <= pick;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= DWELL_LOAD;
                        state_reg <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (cnt_reg == '0 || done) begin
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        last_reg  <= sel_reg;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel       = sel_reg;
    assign sel_valid = valid_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_v_sel_sequencer.sv
// Drives three sequencers (DWELL 1, 4, 8) with directed and random traffic and
// checks every cycle against a behavioural grant model plus literal expectations.
module tb_v_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] req = '0;
    logic       done = 1'b0;
    logic       chk_en = 1'b0;

    logic [2:0] sel_o   [3];
    logic       valid_o [3];
    logic       busy_o  [3];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    v_sel_sequencer #(.DWELL(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .sel(sel_o[0]), .sel_valid(valid_o[0]), .busy(busy_o[0]));
    v_sel_sequencer #(.DWELL(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .sel(sel_o[1]), .sel_valid(valid_o[1]), .busy(busy_o[1]));
    v_sel_sequencer #(.DWELL(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .sel(sel_o[2]), .sel_valid(valid_o[2]), .busy(busy_o[2]));

    function automatic int dw(input int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : 8;
    endfunction

    // First requesting channel after `last`, scanning upward with wrap.
    function automatic int search(input int last, input logic [5:0] r);
        int c;
        for (int j = 1; j <= 6; j++) begin
            c = (last + j) % 6;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    // Model: m_left counts grant cycles still to be shown, including the current one.
    int m_sel   [3] = '{0, 0, 0};
    bit m_valid [3] = '{0, 0, 0};
    int m_left  [3] = '{0, 0, 0};
    int m_last  [3] = '{5, 5, 5};
    bit m_armed = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_sel[k]   <= 0;
                m_valid[k] <= 1'b0;
                m_left[k]  <= 0;
                m_last[k]  <= 5;
            end
            m_armed <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (m_valid[k]) begin
                    if (m_left[k] == 1 || done) begin
                        m_valid[k] <= 1'b0;
                        m_last[k]  <= m_sel[k];
                    end else begin
                        m_left[k] <= m_left[k] - 1;
                    end
                end else if (m_armed && req != 6'd0) begin
                    m_sel[k]   <= search(m_last[k], req);
                    m_valid[k] <= 1'b1;
                    m_left[k]  <= dw(k);
                end
            end
            m_armed <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("model_sel[%0d]", k), 8'(sel_o[k]), 8'(m_sel[k]));
                check($sformatf("model_valid[%0d]", k), 8'(valid_o[k]), 8'(m_valid[k]));
                check($sformatf("model_busy[%0d]", k), 8'(busy_o[k]), 8'(m_valid[k]));
                check($sformatf("sel_range[%0d]", k), 8'(sel_o[k] < 3'd6), 8'd1);
            end
        end
    end

    // Called just after a falling edge: reset lands mid-cycle, checked before any clock edge.
    task automatic reset_pulse(input logic [5:0] next_req);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("async_rst_valid[%0d]", k), 8'(valid_o[k]), 8'd0);
            check($sformatf("async_rst_sel[%0d]", k), 8'(sel_o[k]), 8'd0);
            check($sformatf("async_rst_busy[%0d]", k), 8'(busy_o[k]), 8'd0);
        end
        req = next_req;
        done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        req = 6'b000001;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Single persistent requester: DWELL=4 high 4 / low 1, DWELL=1 alternates.
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            check($sformatf("d4_valid_n%0d", n), 8'(valid_o[1]),
                  8'((n >= 2 && n <= 5) || (n >= 7)));
            check($sformatf("d1_valid_n%0d", n), 8'(valid_o[0]), 8'(n % 2 == 0));
            check($sformatf("d4_sel_n%0d", n), 8'(sel_o[1]), 8'd0);
        end

        // Reset during a DWELL=4 grant; next grant goes to lowest set bit.
        reset_pulse(6'b010100);
        @(negedge clk);
        check("post_rst_idle", 8'(valid_o[1]), 8'd0);
        @(negedge clk);
        check("post_rst_sel", 8'(sel_o[1]), 8'd2);
        check("post_rst_valid", 8'(valid_o[1]), 8'd1);

        // All six requesting, DWELL=1: 0,1,2,3,4,5,0 on alternate cycles.
        @(negedge clk);
        reset_pulse(6'b111111);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            check($sformatf("rr_valid_n%0d", n), 8'(valid_o[0]), 8'(n % 2 == 0));
            if (n % 2 == 0)
                check($sformatf("rr_sel_n%0d", n), 8'(sel_o[0]), 8'((n / 2 - 1) % 6));
        end

        // Wrap from last=3 with req=000101: grant 0, then 2.
        @(negedge clk);
        reset_pulse(6'b001000);
        @(negedge clk);
        @(negedge clk);
        check("wrap_first_sel", 8'(sel_o[0]), 8'd3);
        req = 6'b000101;
        @(negedge clk);
        check("wrap_gap_valid", 8'(valid_o[0]), 8'd0);
        check("wrap_gap_sel", 8'(sel_o[0]), 8'd3);
        @(negedge clk);
        check("wrap_sel0", 8'(sel_o[0]), 8'd0);
        @(negedge clk);
        @(negedge clk);
        check("wrap_sel2", 8'(sel_o[0]), 8'd2);
        check("wrap_valid2", 8'(valid_o[0]), 8'd1);

        // DWELL=8 with done in the third grant cycle.
        @(negedge clk);
        reset_pulse(6'b000001);
        repeat (4) @(negedge clk);
        check("done_3rd_valid", 8'(valid_o[2]), 8'd1);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("done_release", 8'(valid_o[2]), 8'd0);
        @(negedge clk);
        check("done_regrant", 8'(valid_o[2]), 8'd1);

        // req dropped in second grant cycle: DWELL=4 grant still runs 4 cycles.
        @(negedge clk);
        reset_pulse(6'b000010);
        repeat (3) @(negedge clk);
        req = 6'b000000;
        repeat (2) @(negedge clk);
        check("nonpreempt_n5", 8'(valid_o[1]), 8'd1);
        @(negedge clk);
        check("nonpreempt_end", 8'(valid_o[1]), 8'd0);
        repeat (2) @(negedge clk);
        check("hold_sel", 8'(sel_o[1]), 8'd1);
        check("hold_valid", 8'(valid_o[1]), 8'd0);

        // Randomized traffic with occasional done and reset pulses.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) begin
                reset_pulse(6'($urandom_range(0, 63)));
            end else begin
                case ($urandom_range(0, 3))
                    0: req = 6'b000000;
                    1: req = 6'(1 << $urandom_range(0, 5));
                    2: req = 6'($urandom_range(0, 63));
                    default: ;
                endcase
                done = ($urandom_range(0, 9) == 0);
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
